ram_burst_master: RTL and testbench

RAM_BURST_MASTER -- requirements
Module: ram_burst_master

---
 rtl/ram_burst_if.sv | 29 ++
 rtl/ram_burst_master.sv | 158 +++++++++++++++
 tb/tb_ram_burst_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_if.sv
// Command, write-data and read-data streams of ram_burst_master.
// The master modport is the command source side; slave is the burst engine side.
interface ram_burst_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst engine moving write/read streams to one port of a synchronous RAM.
// Define RBM_BOUNDS_CHECK_EN to reject bursts that would wrap, via output err.
module ram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_burst_if.slave            bus,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef RBM_BOUNDS_CHECK_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPT, RD_HOLD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic                  done_q, done_d;
  logic                  last_beat;

`ifdef RBM_BOUNDS_CHECK_EN
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   cmd_end;

  // A carry out of addr + len means the burst would run past the top word.
  assign cmd_end = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign err     = err_q;
`endif

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    rd_last_d     = rd_last_q;
    done_d        = 1'b0;
`ifdef RBM_BOUNDS_CHECK_EN
    err_d         = 1'b0;
`endif
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = ram_addr_q;
    ram_din       = bus.wr_data;

    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          len_d  = bus.cmd_len;
          cnt_d  = '0;
`ifdef RBM_BOUNDS_CHECK_EN
          if (cmd_end[ADDR_WIDTH]) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else
`endif
          state_d = bus.cmd_write ? WR : RD_ISSUE;
        end
      end
      WR: begin
        bus.wr_ready = 1'b1;
        ram_addr     = addr_q;
        ram_we       = bus.wr_valid;
        if (bus.wr_valid) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        ram_addr = addr_q;
        state_d  = RD_CAPT;
      end
      RD_CAPT: begin
        // ram_dout now reflects the address issued in the previous cycle.
        rd_data_d  = ram_dout;
        rd_valid_d = 1'b1;
        rd_last_d  = last_beat;
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          addr_d     = addr_q + 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef RBM_BOUNDS_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
`ifdef RBM_BOUNDS_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_last  = rd_last_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master: directed bursts against a behavioural RAM,
// with a negedge monitor checking RAM writes, read beats and done pulses.
module tb_ram_burst_master;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic          busy, done, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
`ifdef RBM_BOUNDS_CHECK_EN
  logic          err;
`endif

  ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
`ifdef RBM_BOUNDS_CHECK_EN
    ,
    .err      (err)
`endif
  );

  // Synchronous RAM, read-before-write, not affected by rst_n.
  logic [DW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [DW-1:0] d; logic last; int gap; } rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  bit  exp_done[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  always @(negedge clk) begin
    if (ram_we) begin
      if (exp_wr.size() == 0) chk("unexpected_ram_we", {28'd0, ram_addr}, 32'hFFFF_FFFF);
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", ram_addr, w.a);
        chk("wr_data", ram_din, w.d);
        $display("wr  addr=%0d data=%02h", ram_addr, ram_din);
      end
    end
    if (bus.rd_valid && bus.rd_ready) begin
      if (exp_rd.size() == 0) chk("unexpected_rd_beat", bus.rd_data, 32'hFFFF_FFFF);
      else begin
        rd_t r;
        r = exp_rd.pop_front();
        chk("rd_data", bus.rd_data, r.d);
        chk("rd_last", bus.rd_last, r.last);
        if (r.gap != 0) chk("rd_gap", cyc - last_rd_cyc, r.gap);
        $display("rd  data=%02h last=%0b", bus.rd_data, bus.rd_last);
      end
      last_rd_cyc = cyc;
    end
    if (done) begin
      if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        bit e;
        e = exp_done.pop_front();
`ifdef RBM_BOUNDS_CHECK_EN
        chk("done_err", err, e);
`else
        if (e) chk("done_err_expected", 0, 1);
`endif
        $display("done");
      end
    end
`ifdef RBM_BOUNDS_CHECK_EN
    else if (err) chk("err_without_done", err, 0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input int len, input logic [DW-1:0] base,
                          input logic [DW-1:0] step);
    for (int i = 0; i <= len; i++)
      exp_wr.push_back('{a: AW'(addr + i), d: DW'(base + DW'(i) * step)});
    exp_done.push_back(1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = AW'(len);
    bus.wr_valid  = 1'b1;
    bus.wr_data   = base;
    tick();
    bus.cmd_valid = 1'b0;
    chk("wr_accept_busy", busy, 1);
    for (int i = 0; i <= len; i++) begin
      tick();
      bus.wr_data = DW'(base + DW'(i + 1) * step);
    end
    bus.wr_valid = 1'b0;
    chk("wr_done_pulse", done, 1);
    chk("wr_idle_after", busy, 0);
    tick();
    chk("wr_done_one_cycle", done, 0);
  endtask

  task automatic do_read(input int addr, input int len, input logic [DW-1:0] base,
                         input logic [DW-1:0] step);
    bit seen;
    for (int i = 0; i <= len; i++)
      exp_rd.push_back('{d: DW'(base + DW'(i) * step), last: (i == len), gap: (i == 0) ? 0 : 3});
    exp_done.push_back(1'b0);
    bus.rd_ready  = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = AW'(len);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rd_accept_busy", busy, 1);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        chk("rd_done_after_last", cyc - last_rd_cyc, 1);
      end
    end
    chk("rd_done_seen", seen, 1);
    tick();
    chk("rd_done_one_cycle", done, 0);
  endtask

  initial begin
    bit seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    rst_n = 1'b1;

    // First command right after reset release; then read it back with rd_ready high.
    do_write(3, 3, 8'hA1, 8'h01);
    do_read(3, 3, 8'hA1, 8'h01);

    // Backpressure: hold rd_ready low for 5 cycles on the first beat.
    exp_rd.push_back('{d: 8'hA1, last: 1'b0, gap: 0});
    exp_rd.push_back('{d: 8'hA2, last: 1'b1, gap: 0});
    exp_done.push_back(1'b0);
    bus.rd_ready  = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 4'd3;
    bus.cmd_len   = 4'd1;
    tick();
    bus.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = bus.rd_valid;
    end
    chk("bp_first_valid", seen, 1);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("bp_hold_valid", bus.rd_valid, 1);
      chk("bp_hold_data", bus.rd_data, 8'hA1);
      chk("bp_hold_last", bus.rd_last, 0);
      chk("bp_hold_addr", ram_addr, 3);
    end
    bus.rd_ready = 1'b1;
    tick();
    chk("bp_valid_cleared", bus.rd_valid, 0);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = done;
    end
    chk("bp_done_seen", seen, 1);
    tick();

`ifdef RBM_BOUNDS_CHECK_EN
    // Out-of-range burst: accepted, err+done pulse, no RAM traffic.
    exp_done.push_back(1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 4'd14;
    bus.cmd_len   = 4'd2;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'h11;
    tick();
    bus.cmd_valid = 1'b0;
    chk("oob_stay_idle", busy, 0);
    chk("oob_done", done, 1);
    chk("oob_err", err, 1);
    tick();
    bus.wr_valid = 1'b0;
    chk("oob_done_clear", done, 0);
    chk("oob_err_clear", err, 0);
    chk("oob_mem14", mem[14], 0);
    tick();
`else
    // Address wrap 14,15,0.
    do_write(14, 2, 8'h11, 8'h11);
    do_read(14, 2, 8'h11, 8'h11);
`endif

    // Reset in the middle of a 4-beat write, after two beats landed.
    exp_wr.push_back('{a: 4'd8, d: 8'hB1});
    exp_wr.push_back('{a: 4'd9, d: 8'hB2});
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 4'd8;
    bus.cmd_len   = 4'd3;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'hB1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.wr_data = 8'hB2;
    tick();
    bus.wr_data = 8'hB3;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_ready", bus.wr_ready, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    tick();
    chk("mid_rst_no_done", done, 0);
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    chk("mid_rst_mem8", mem[8], 8'hB1);
    chk("mid_rst_mem9", mem[9], 8'hB2);
    chk("mid_rst_mem10", mem[10], 8'h00);
    do_read(8, 1, 8'hB1, 8'h01);

    chk("left_wr", exp_wr.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_done", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
